// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus arbiter.
// Reused by the CPU top level and the loader.
package mem_bus_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic {
    OWN_M0,
    OWN_M1
  } owner_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master-side and memory-side bus signals of the arbiter.
// slave = arbiter view, master = requester/memory view.
interface mem_bus_arbiter_if;
  import mem_bus_pkg::*;

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_done;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_done;

  logic [DATA_W-1:0] m_rdata;
  logic              m_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_w;
  logic              mem_req;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              timeout_err;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_ready, mem_rdata,
    output m0_done, m1_done, m_rdata, m_err,
    output mem_addr, mem_wdata, mem_w, mem_req,
    output timeout_err
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_ready, mem_rdata,
    input  m0_done, m1_done, m_rdata, m_err,
    input  mem_addr, mem_wdata, mem_w, mem_req,
    input  timeout_err
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Two-way grant selection for the memory arbiter.
// Round-robin on last grant, or fixed M0 priority.
module arb_rr_pick
  import mem_bus_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic   req0,
  input  logic   req1,
  input  owner_t last,
  output logic   any,
  output owner_t win
);

  // Winner: contested grant goes to the master not served last
  always_comb begin
    any = req0 | req1;
    win = OWN_M0;
    unique case (1'b1)
      req0 && req1:
        win = (FIXED_PRIO || last == OWN_M1)
            ? OWN_M0 : OWN_M1;
      req1 && !req0:
        win = OWN_M1;
      default:
        win = OWN_M0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between CPU (M0) and loader (M1).
// One registered transaction per grant, with a watchdog.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int              FIXED_PRIO = 0,
  parameter int              TIMEOUT    = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 16'hFFFF
) (
  input logic clk,
  input logic rst_n,
  mem_bus_arbiter_if.slave bus
);

  localparam logic [15:0] TO_LIM = TIMEOUT[15:0];

  state_t            state;
  owner_t            owner;
  owner_t            last;
  logic [15:0]       cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              req_q;
  logic              w_q;
  logic              err_q;
  logic              terr_q;
  logic              done0_q;
  logic              done1_q;

  logic              any;
  owner_t            win;
  logic [15:0]       cnt_inc;
  logic              hit_to;

  arb_rr_pick #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_pick (
    .req0 (bus.m0_req),
    .req1 (bus.m1_req),
    .last (last),
    .any  (any),
    .win  (win)
  );

  // Saturating watchdog step and abort test
  always_comb begin
    cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    hit_to  = (cnt_inc >= TO_LIM);
  end

  // Arbitration FSM, request latches and watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= OWN_M0;
      last    <= OWN_M1;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      w_q     <= 1'b0;
      err_q   <= 1'b0;
      terr_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            owner <= win;
            last  <= win;
            cnt   <= '0;
            req_q <= 1'b1;
            state <= BUSY;
            if (win == OWN_M1) begin
              we_q    <= bus.m1_we;
              w_q     <= bus.m1_we;
              addr_q  <= bus.m1_addr;
              wdata_q <= bus.m1_wdata;
            end else begin
              we_q    <= bus.m0_we;
              w_q     <= bus.m0_we;
              addr_q  <= bus.m0_addr;
              wdata_q <= bus.m0_wdata;
            end
          end
        end
        BUSY: begin
          cnt <= cnt_inc;
          if (bus.mem_ready || hit_to) begin
            req_q   <= 1'b0;
            w_q     <= 1'b0;
            state   <= DONE;
            done0_q <= (owner == OWN_M0);
            done1_q <= (owner == OWN_M1);
            if (bus.mem_ready) begin
              err_q <= 1'b0;
              if (!we_q) rdata_q <= bus.mem_rdata;
            end else begin
              err_q  <= 1'b1;
              terr_q <= 1'b1;
              if (!we_q) rdata_q <= ERR_DATA;
            end
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req     = req_q;
  assign bus.mem_w       = w_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.m_rdata     = rdata_q;
  assign bus.m_err       = err_q;
  assign bus.timeout_err = terr_q;
  assign bus.m0_done     = done0_q;
  assign bus.m1_done     = done1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter.
// Round-robin DUT plus a fixed-priority DUT.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  typedef struct packed {
    logic        own;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus ();
  mem_bus_arbiter_if bus2 ();

  mem_bus_arbiter #(
    .FIXED_PRIO (0),
    .TIMEOUT    (4),
    .ERR_DATA   (16'hFFFF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mem_bus_arbiter #(
    .FIXED_PRIO (1),
    .TIMEOUT    (4),
    .ERR_DATA   (16'hFFFF)
  ) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  // Fixed-priority DUT sees an always-fast memory
  assign bus2.mem_ready = bus2.mem_req;
  assign bus2.mem_rdata = 16'h00A0;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t q2[$];

  int          mem_lat = 0;
  logic [15:0] mem_data = '0;

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic own,
                              logic [15:0] d,
                              logic e);
    exp_t x;
    x.own = own;
    x.rdata = d;
    x.err = e;
    return x;
  endfunction

  // Memory model: ready after mem_lat BUSY cycles, 0 = never
  initial begin
    int c;
    c = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        c++;
        if (mem_lat != 0 && c == mem_lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_data;
        end else begin
          bus.mem_ready = 1'b0;
        end
      end else begin
        c = 0;
        bus.mem_ready = 1'b0;
      end
    end
  end

  // Monitor for the round-robin DUT
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.m0_done || bus.m1_done) begin
        chk("done_width", {31'd0, prev}, 32'd0);
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: m0=%b m1=%b",
                   bus.m0_done, bus.m1_done);
        end else begin
          e = q.pop_front();
          chk("done_owner",
              {30'd0, bus.m1_done, bus.m0_done},
              e.own ? 32'd2 : 32'd1);
          chk("m_rdata", {16'd0, bus.m_rdata},
              {16'd0, e.rdata});
          chk("m_err", {31'd0, bus.m_err},
              {31'd0, e.err});
        end
      end
      prev = bus.m0_done | bus.m1_done;
    end
  end

  // Monitor for the fixed-priority DUT
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus2.m0_done || bus2.m1_done) begin
        if (q2.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL fp_unexpected_done: m0=%b m1=%b",
                   bus2.m0_done, bus2.m1_done);
        end else begin
          e = q2.pop_front();
          chk("fp_owner",
              {30'd0, bus2.m1_done, bus2.m0_done},
              e.own ? 32'd2 : 32'd1);
          chk("fp_rdata", {16'd0, bus2.m_rdata},
              {16'd0, e.rdata});
        end
      end
    end
  end

  task automatic wait_done(input bit m,
                           output int busy);
    bit ok;
    ok = 1'b0;
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mem_req) busy++;
      if (m ? bus.m1_done : bus.m0_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: master %0d no done", m);
    end
  endtask

  task automatic run_one(input bit m,
                         input logic we,
                         input logic [15:0] a,
                         input logic [15:0] d,
                         input exp_t e);
    int busy;
    q.push_back(e);
    if (m) begin
      bus.m1_we = we;
      bus.m1_addr = a;
      bus.m1_wdata = d;
      bus.m1_req = 1'b1;
    end else begin
      bus.m0_we = we;
      bus.m0_addr = a;
      bus.m0_wdata = d;
      bus.m0_req = 1'b1;
    end
    wait_done(m, busy);
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench stalled");
    $fatal(1, "global timeout");
  end

  initial begin
    int busy;
    int nd;
    bit ok;

    rst_n = 1'b0;
    bus.m0_req = 0; bus.m0_we = 0;
    bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0;
    bus.m1_addr = '0; bus.m1_wdata = '0;
    bus2.m0_req = 0; bus2.m0_we = 0;
    bus2.m0_addr = '0; bus2.m0_wdata = '0;
    bus2.m1_req = 0; bus2.m1_we = 0;
    bus2.m1_addr = '0; bus2.m1_wdata = '0;

    // Reset state
    #12;
    chk("rst_mem_req", {31'd0, bus.mem_req}, 0);
    chk("rst_mem_w", {31'd0, bus.mem_w}, 0);
    chk("rst_mem_addr", {16'd0, bus.mem_addr}, 0);
    chk("rst_mem_wdata", {16'd0, bus.mem_wdata}, 0);
    chk("rst_m_rdata", {16'd0, bus.m_rdata}, 0);
    chk("rst_m_err", {31'd0, bus.m_err}, 0);
    chk("rst_done",
        {30'd0, bus.m1_done, bus.m0_done}, 0);
    chk("rst_terr", {31'd0, bus.timeout_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_mem_req", {31'd0, bus.mem_req}, 0);
    end

    // M0 read, memory answers after 2 cycles
    mem_lat = 2;
    mem_data = 16'hBEEF;
    q.push_back(mk(1'b0, 16'hBEEF, 1'b0));
    bus.m0_we = 1'b0;
    bus.m0_addr = 16'h0020;
    bus.m0_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        chk("rd_mem_w", {31'd0, bus.mem_w}, 0);
        chk("rd_mem_addr", {16'd0, bus.mem_addr},
            32'h0020);
      end
      if (bus.m0_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rd_done_seen", {31'd0, ok}, 1);
    bus.m0_req = 1'b0;
    @(negedge clk);

    // Both held: last grant was M0, so M1 first
    mem_lat = 1;
    mem_data = 16'h5A5A;
    q.push_back(mk(1'b1, 16'h5A5A, 1'b0));
    q.push_back(mk(1'b0, 16'h5A5A, 1'b0));
    q.push_back(mk(1'b1, 16'h5A5A, 1'b0));
    q.push_back(mk(1'b0, 16'h5A5A, 1'b0));
    bus.m0_addr = 16'h0100;
    bus.m1_addr = 16'h0200;
    bus.m1_we = 1'b0;
    bus.m0_req = 1'b1;
    bus.m1_req = 1'b1;
    nd = 0;
    for (int i = 0; i < 100 && nd < 4; i++) begin
      @(negedge clk);
      if (bus.m0_done || bus.m1_done) nd++;
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    chk("rr_done_count", nd, 4);
    @(negedge clk);

    // M1 write; inputs changed mid-BUSY must not leak
    mem_lat = 3;
    q.push_back(mk(1'b1, 16'h5A5A, 1'b0));
    bus.m1_we = 1'b1;
    bus.m1_addr = 16'h00FE;
    bus.m1_wdata = 16'h1234;
    bus.m1_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        chk("wr_mem_w", {31'd0, bus.mem_w}, 1);
        chk("wr_mem_addr", {16'd0, bus.mem_addr},
            32'h00FE);
        chk("wr_mem_wdata", {16'd0, bus.mem_wdata},
            32'h1234);
        bus.m1_addr = 16'hDEAD;
        bus.m1_wdata = 16'h0000;
        bus.m1_we = 1'b0;
      end
      if (bus.m1_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wr_done_seen", {31'd0, ok}, 1);
    bus.m1_req = 1'b0;
    @(negedge clk);

    // Timeout: memory never ready
    mem_lat = 0;
    chk("pre_terr", {31'd0, bus.timeout_err}, 0);
    q.push_back(mk(1'b0, 16'hFFFF, 1'b1));
    bus.m0_we = 1'b0;
    bus.m0_addr = 16'h0040;
    bus.m0_req = 1'b1;
    wait_done(1'b0, busy);
    bus.m0_req = 1'b0;
    chk("to_busy_cycles", busy, 4);
    chk("to_terr", {31'd0, bus.timeout_err}, 1);
    @(negedge clk);

    // Good transaction after abort: sticky flag stays
    mem_lat = 1;
    mem_data = 16'h1111;
    run_one(1'b1, 1'b0, 16'h0300, 16'h0,
            mk(1'b1, 16'h1111, 1'b0));
    @(negedge clk);
    chk("terr_sticky", {31'd0, bus.timeout_err}, 1);

    // Fixed priority: M0 wins while held
    q2.push_back(mk(1'b0, 16'h00A0, 1'b0));
    q2.push_back(mk(1'b0, 16'h00A0, 1'b0));
    q2.push_back(mk(1'b0, 16'h00A0, 1'b0));
    q2.push_back(mk(1'b0, 16'h00A0, 1'b0));
    bus2.m0_req = 1'b1;
    bus2.m1_req = 1'b1;
    nd = 0;
    for (int i = 0; i < 100 && nd < 4; i++) begin
      @(negedge clk);
      if (bus2.m0_done || bus2.m1_done) nd++;
    end
    bus2.m0_req = 1'b0;
    bus2.m1_req = 1'b0;
    chk("fp_done_count", nd, 4);
    @(negedge clk);

    // Reset pulse during a BUSY write
    mem_lat = 0;
    bus.m0_we = 1'b1;
    bus.m0_addr = 16'h0050;
    bus.m0_wdata = 16'h7777;
    bus.m0_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_mem_w", {31'd0, bus.mem_w}, 1);
    #2;
    rst_n = 1'b0;
    bus.m0_req = 1'b0;
    #1;
    chk("arst_mem_req", {31'd0, bus.mem_req}, 0);
    chk("arst_mem_w", {31'd0, bus.mem_w}, 0);
    chk("arst_terr", {31'd0, bus.timeout_err}, 0);
    chk("arst_rdata", {16'd0, bus.m_rdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    mem_lat = 1;
    mem_data = 16'h2222;
    run_one(1'b0, 1'b0, 16'h0060, 16'h0,
            mk(1'b0, 16'h2222, 1'b0));

    repeat (5) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    chk("fp_sb_empty", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
